stack_memory: RTL

Hardware LIFO stack serving the stack CPU datapath. It responds to the `push`, `pop` and `tos` strobes issued by the multicycle controller. It supplies the top-of-stack word combinationally, so the A or B operand register can capture it on the same edge that retires a pop. It also tracks depth and flags overflow and underflow.

---
 rtl/stack_memory.sv | 107 ++++++++++
 1 files changed

// File: rtl/stack_memory.sv
// LIFO operand stack for the stack CPU datapath: combinational top-of-stack read,
// depth tracking, and sticky overflow/underflow flags with a two-state error FSM.
module stack_memory #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic             tos,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   output logic             err_state
);

   // Handshake: strobes are single-cycle commands sampled at the rising edge; there is
   // no ready, the stack accepts a command every cycle and rejects illegal ones by flag.

   typedef enum logic {ST_OK = 1'b0, ST_ERR = 1'b1} state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      sp, sp_n, sp_m1;
   logic             overflow_n, underflow_n;
   logic             we;
   logic [AW-1:0]    waddr;
   state_t           state, state_n;

   assign sp_m1      = sp - ONE_W;
   assign count      = sp;
   assign empty      = (sp == '0);
   assign full       = (sp == DEPTH_W);
   assign dout       = empty ? '0 : mem[sp_m1[AW-1:0]];
   assign dout_valid = (pop | tos) & ~empty;
   assign err_state  = (state == ST_ERR);

   always_comb begin
      sp_n        = sp;
      overflow_n  = overflow;
      underflow_n = underflow;
      we          = 1'b0;
      waddr       = sp[AW-1:0];
      if (clr) begin
         sp_n        = '0;
         overflow_n  = 1'b0;
         underflow_n = 1'b0;
      end else if (push && pop && !empty) begin
         we    = 1'b1;
         waddr = sp_m1[AW-1:0];
      end else if (push && pop) begin
         // Pop of an empty stack is rejected but the push half still lands in slot 0.
         we          = 1'b1;
         waddr       = '0;
         sp_n        = ONE_W;
         underflow_n = 1'b1;
      end else if (push && !full) begin
         we   = 1'b1;
         sp_n = sp + ONE_W;
      end else if (push) begin
         overflow_n = 1'b1;
      end else if (pop && !empty) begin
         sp_n = sp_m1;
      end else if (pop) begin
         underflow_n = 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      if (clr)
         state_n = ST_OK;
      if (overflow_n || underflow_n)
         state_n = ST_ERR;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         state     <= ST_OK;
      end else begin
         sp        <= sp_n;
         overflow  <= overflow_n;
         underflow <= underflow_n;
         state     <= state_n;
      end
   end

   // Storage is deliberately left out of reset; only the pointer defines valid contents.
   always_ff @(posedge clk) begin
      if (we && !reset)
         mem[waddr] <= din;
   end

endmodule
